// File: rtl/voice_mix_pkg.sv
// Shared defaults, FSM encoding and gain shift for the voice mixer.
// The optional gain path is enabled by defining VOICE_MIX_GAIN_EN.
package voice_mix_pkg;

  localparam int dflt_dsz   = 12;
  localparam int dflt_vsz   = 4;
  localparam int dflt_asz   = 17;
  localparam int gain_shift = 8;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_scan  = 2'd1,
    st_drain = 2'd2,
    st_done  = 2'd3
  } mix_state_t;

endpackage

// File: rtl/voice_mix_if.sv
// Sample RAM port between the mixer (master) and the voice engine RAM (slave).
// Data and gain for an address arrive one cycle after the address.
interface voice_mix_if
  import voice_mix_pkg::*;
#(
  parameter int dsz = dflt_dsz,
  parameter int vsz = dflt_vsz
) ();

  logic        [vsz-1:0] voice_sel;
  logic signed [dsz-1:0] voice_data;
  logic        [7:0]     voice_gain;

  modport master (
    output voice_sel,
    input  voice_data,
    input  voice_gain
  );

  modport slave (
    input  voice_sel,
    output voice_data,
    output voice_gain
  );

endinterface

// File: rtl/voice_mix_gain_mul.sv
// Registered signed sample x unsigned gain, arithmetic-shifted by gain_shift.
// Only instantiated by voice_mix when VOICE_MIX_GAIN_EN is defined.
module voice_gain_mul
  import voice_mix_pkg::*;
#(
  parameter int dsz = dflt_dsz
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic signed [dsz-1:0] data,
  input  logic        [7:0]     gain,
  output logic signed [dsz:0]   term
);

  logic signed [dsz+8:0] prod;

  // Zero-extended gain keeps the multiply signed; >>> floors toward -inf.
  assign prod = data * $signed({1'b0, gain});

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      term <= '0;
    end else begin
      term <= (dsz+1)'(prod >>> gain_shift);
    end
  end

endmodule

// File: rtl/voice_mix.sv
// Time-multiplexed voice mixer: scans nv voices per ena strobe and sums them.
// Define VOICE_MIX_GAIN_EN to scale each sample by its 8-bit gain (one extra stage).
module voice_mix
  import voice_mix_pkg::*;
#(
  parameter int dsz = dflt_dsz,
  parameter int vsz = dflt_vsz,
  parameter int asz = dflt_asz
)
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  voice_mix_if.master           vbus,
  output logic signed [asz-1:0] mix,
  output logic                  mix_valid,
  output logic                  busy,
  output logic                  overrun
);

  localparam logic [vsz-1:0] last_sel = '1;

  mix_state_t state;
  mix_state_t next_state;

  logic        [vsz-1:0] cnt;
  logic                  data_vld;
  logic                  add_vld;
  logic                  feed_empty;
  logic signed [asz-1:0] term;
  logic signed [asz-1:0] acc;
  logic signed [asz-1:0] acc_sum;

`ifdef VOICE_MIX_GAIN_EN
  logic signed [dsz:0] prod;
  logic                prod_vld;

  voice_gain_mul #(.dsz(dsz)) u_gain_mul (
    .clk   (clk),
    .reset (reset),
    .data  (vbus.voice_data),
    .gain  (vbus.voice_gain),
    .term  (prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= data_vld;
    end
  end

  assign term       = asz'(prod);
  assign add_vld    = prod_vld;
  assign feed_empty = !data_vld;
`else
  logic unused_gain;

  assign unused_gain = ^vbus.voice_gain;
  assign term        = asz'(vbus.voice_data);
  assign add_vld     = data_vld;
  assign feed_empty  = 1'b1;
`endif

  assign acc_sum = add_vld ? acc + term : acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= st_idle;
    end else begin
      state <= next_state;
    end
  end

  // DRAIN waits until only the final accumulate stage still holds a sample.
  always_comb begin
    next_state = state;
    case (state)
      st_idle:  if (ena) next_state = st_scan;
      st_scan:  if (cnt == last_sel) next_state = st_drain;
      st_drain: if (feed_empty) next_state = st_done;
      st_done:  next_state = st_idle;
      default:  next_state = st_idle;
    endcase
  end

  always_comb begin
    busy           = (state != st_idle);
    mix_valid      = (state == st_done);
    vbus.voice_sel = (state == st_scan) ? cnt : '0;
  end

  // The mix register takes the final sum on the edge into DONE so it is
  // visible in the same cycle mix_valid pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      data_vld <= 1'b0;
      acc      <= '0;
      mix      <= '0;
      overrun  <= 1'b0;
    end else begin
      data_vld <= (state == st_scan);
      cnt      <= (state == st_scan) ? cnt + 1'b1 : '0;
      if (state == st_idle && ena) begin
        acc <= '0;
      end else begin
        acc <= acc_sum;
      end
      if (state == st_drain && next_state == st_done) begin
        mix <= acc_sum;
      end
      if (ena && state != st_idle) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule
